mem_streams_rd_ctrl: RTL and testbench
======================================

# mem_streams_rd_ctrl

Read-side controller for the per-channel stream memories. It drives read enable and address into the memory block and absorbs the fixed READ_LATENCY of the RAM. It re-frames the CHANNELS-wide read data into a valid/ready stream with per-pass last and pass-index tags, and supports repeated passes over the same stored frame. It sits between the stream RAM bank and the downstream beam/MAC consumers, which may apply backpressure.

## Interface
- CHANNELS, 16, number of parallel channel lanes
- DATA_WIDTH, 64, bits per channel lane
- ADDR_WIDTH, 11, memory address width
- READ_LATENCY, 3, cycles from o_rd_ren to valid i_rd_data (≥1)
- REPEAT_WIDTH, 4, width of repeat count
- FIFO_DEPTH, 8, output FIFO depth; power of two, ≥ READ_LATENCY+2

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  single-cycle pulse; begin reading a stored frame
- i_frame_len  in  ADDR_WIDTH  words per channel; sampled on accepted i_start
- i_repeat  in  REPEAT_WIDTH  pass count minus 1; sampled on accepted i_start
- o_rd_ren  out  1  memory read enable
- o_rd_addr  out  ADDR_WIDTH  address qualified by o_rd_ren
- i_rd_data  in  CHANNELS*DATA_WIDTH  memory data, valid READ_LATENCY cycles after o_rd_ren
- o_tdata  out  CHANNELS*DATA_WIDTH  output data, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- o_tvalid  out  1  output valid
- i_tready  in  1  downstream ready
- o_tlast  out  1  last word of current pass
- o_tuser  out  REPEAT_WIDTH  pass index (0..i_repeat) of current word
- o_busy  out  1  high from accepted start until o_done
- o_done  out  1  single-cycle pulse when all passes have been delivered

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - i_start with i_frame_len≠0: latch len and repeat, clear addr and pass, go to RUN, o_busy=1.
  - i_start with i_frame_len=0: o_done pulses the next cycle; FSM stays in IDLE; no reads issued.
- i_start while o_busy=1 is ignored.
- RUN:
  - Issue one read per cycle when credit is available: inflight + fifo_count < FIFO_DEPTH. inflight is the number of reads issued but not yet returned (≤ READ_LATENCY).
  - Each issued read carries its address, and a tag {last = (addr==len-1), pass}, through a READ_LATENCY-deep shift register alongside its valid bit.
  - Address increments by 1. At addr==len-1 it wraps to 0 and pass increments.
  - The issue at addr==len-1 with pass==repeat is the final read; the FSM goes to DRAIN.
- Return path: when the delayed valid is set, {i_rd_data, last, pass} is written into the FIFO.
  - FIFO is show-ahead: o_tdata/o_tlast/o_tuser reflect the head entry whenever o_tvalid=1.
  - Pop on o_tvalid & i_tready.
- Credit rule: the FIFO never overflows.
- DRAIN: when inflight=0, FIFO empty, and no pop in progress, pulse o_done for 1 cycle, deassert o_busy, return to IDLE.
- Simultaneous FIFO write and pop in the same cycle: count unchanged, both succeed.
- o_tvalid, once asserted, holds until popped. o_tdata, o_tlast and o_tuser stay stable while o_tvalid=1 and i_tready=0.
- Reset (any state, including mid-RUN/DRAIN):
  - FSM returns to IDLE; FIFO, inflight and shift register are cleared.
  - Data in flight is discarded; no o_done is generated.
- Widths: internal pass counter is REPEAT_WIDTH bits; addr counter is ADDR_WIDTH bits; inflight/fifo_count are $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset value of all outputs: o_rd_ren=0, o_rd_addr=0, o_tvalid=0, o_tlast=0, o_tuser=0, o_tdata=0, o_busy=0, o_done=0.
- i_start accepted at cycle T:
  - first o_rd_ren at T+1 with o_rd_addr=0;
  - first FIFO write at T+1+READ_LATENCY;
  - first o_tvalid at T+2+READ_LATENCY.
- With i_tready held 1:
  - o_rd_ren is continuous, giving one output word per cycle with no bubbles, including across pass boundaries.
  - Total reads = len*(repeat+1).
  - o_done follows the final pop by 1 cycle.
- All outputs are registered. i_rd_data is captured on the cycle the delayed valid bit is set.

## Test plan
- len=4, repeat=0, i_tready=1, memory returns addr-tagged data:
  - o_rd_addr 0,1,2,3 at T+1..T+4;
  - 4 beats from T+5 (L=3), o_tlast on the 4th, o_tuser=0;
  - o_done at T+9.
- len=3, repeat=2:
  - 9 contiguous reads, addr 0,1,2,0,1,2,0,1,2;
  - o_tuser 0,0,0,1,1,1,2,2,2;
  - o_tlast on beats 3, 6 and 9.
- len=20, i_tready low for 15 cycles after first o_tvalid, then toggling:
  - o_rd_ren stops once inflight+count=8;
  - no data lost or duplicated; outputs stable while stalled;
  - exactly 20 beats delivered, then o_done.
- i_start with len=0: o_done at T+1, o_busy stays 0, no o_rd_ren.
- Second i_start during RUN: ignored; beat count and tags match the first request only.
- Assert i_reset mid-RUN with the FIFO partially full:
  - all outputs 0 next cycle, no o_done;
  - a new start afterwards behaves as in scenario 1.

Source files
------------

// File: rtl/mem_streams_rd_ctrl.sv
// rtl/mem_streams_rd_ctrl.sv - stream RAM read controller with latency absorption, repeat passes and show-ahead output FIFO
module mem_streams_rd_ctrl #(
  parameter int CHANNELS     = 16,
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 3,
  parameter int REPEAT_WIDTH = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [ADDR_WIDTH-1:0]          i_frame_len,
  input  logic [REPEAT_WIDTH-1:0]        i_repeat,
  output logic                           o_rd_ren,
  output logic [ADDR_WIDTH-1:0]          o_rd_addr,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_rd_data,
  output logic [CHANNELS*DATA_WIDTH-1:0] o_tdata,
  output logic                           o_tvalid,
  input  logic                           i_tready,
  output logic                           o_tlast,
  output logic [REPEAT_WIDTH-1:0]        o_tuser,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int WW = CHANNELS * DATA_WIDTH;
  localparam int EW = WW + 1 + REPEAT_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_n;

  // frame setup and issue counters
  logic [ADDR_WIDTH-1:0]   len_q, len_n;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
  logic [REPEAT_WIDTH-1:0] rep_q, rep_n;
  logic [REPEAT_WIDTH-1:0] pass_q, pass_n;

  // operands of the read being decided this cycle (start bypasses the registers)
  logic [ADDR_WIDTH-1:0]   cur_len, cur_addr;
  logic [REPEAT_WIDTH-1:0] cur_rep, cur_pass;
  logic                    issue;

  // registered read port and the tag travelling with it
  logic                    ren_n;
  logic [ADDR_WIDTH-1:0]   raddr_n;
  logic                    last_n, rd_last_q;
  logic [REPEAT_WIDTH-1:0] tpass_n, rd_pass_q;
  logic                    done_n, busy_n;

  // latency-matching pipeline
  logic [READ_LATENCY-1:0] pv_q;
  logic [READ_LATENCY-1:0] pl_q;
  logic [REPEAT_WIDTH-1:0] pp_q [READ_LATENCY];
  logic [CW-1:0]           inflight;

  // output FIFO
  logic [EW-1:0]           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_push, fifo_pop;
  logic [EW-1:0]           head;

  logic                    credit_ok, drain_ok;

  assign fifo_push = pv_q[READ_LATENCY-1];
  assign fifo_pop  = o_tvalid & i_tready;

  // Reads whose data has not yet landed in the FIFO
  always_comb begin
    inflight = '0;
    for (int k = 0; k < READ_LATENCY; k++) begin
      inflight = inflight + CW'(pv_q[k]);
    end
  end

  // The read on the port right now also owns a FIFO slot, so it is counted too
  assign credit_ok = (CW'(o_rd_ren) + inflight + fifo_count) < DEPTH_C;

  // Finishing when the last entry is being popped lets o_done land one cycle after the final pop
  assign drain_ok = !o_rd_ren && (pv_q == '0) &&
                    ((fifo_count == '0) || ((fifo_count == CW'(1)) && fifo_pop));

  // Next-state, issue decision and next values of the registered control outputs
  always_comb begin
    state_n  = state;
    len_n    = len_q;
    rep_n    = rep_q;
    addr_n   = addr_q;
    pass_n   = pass_q;
    cur_len  = len_q;
    cur_rep  = rep_q;
    cur_addr = addr_q;
    cur_pass = pass_q;
    issue    = 1'b0;
    done_n   = 1'b0;
    ren_n    = 1'b0;
    raddr_n  = o_rd_addr;
    last_n   = rd_last_q;
    tpass_n  = rd_pass_q;

    case (state)
      S_IDLE: begin
        if (i_start) begin
          if (i_frame_len != '0) begin
            len_n    = i_frame_len;
            rep_n    = i_repeat;
            cur_len  = i_frame_len;
            cur_rep  = i_repeat;
            cur_addr = '0;
            cur_pass = '0;
            issue    = 1'b1;
            state_n  = S_RUN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      S_RUN: begin
        issue = credit_ok;
      end
      S_DRAIN: begin
        if (drain_ok) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (issue) begin
      ren_n   = 1'b1;
      raddr_n = cur_addr;
      tpass_n = cur_pass;
      last_n  = (cur_addr == (cur_len - ADDR_WIDTH'(1)));
      if (last_n) begin
        addr_n = '0;
        pass_n = cur_pass + REPEAT_WIDTH'(1);
        if (cur_pass == cur_rep) begin
          state_n = S_DRAIN;
        end
      end else begin
        addr_n = cur_addr + ADDR_WIDTH'(1);
        pass_n = cur_pass;
      end
    end

    busy_n = (state_n != S_IDLE);
  end

  // FSM state, frame setup, counters and registered read port / status outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      rep_q     <= '0;
      addr_q    <= '0;
      pass_q    <= '0;
      o_rd_ren  <= 1'b0;
      o_rd_addr <= '0;
      rd_last_q <= 1'b0;
      rd_pass_q <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      rep_q     <= rep_n;
      addr_q    <= addr_n;
      pass_q    <= pass_n;
      o_rd_ren  <= ren_n;
      o_rd_addr <= raddr_n;
      rd_last_q <= last_n;
      rd_pass_q <= tpass_n;
      o_busy    <= busy_n;
      o_done    <= done_n;
    end
  end

  // Shift valid and tag of each read so they meet the RAM data READ_LATENCY cycles later
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pv_q <= '0;
      pl_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pp_q[k] <= '0;
      end
    end else begin
      pv_q[0] <= o_rd_ren;
      pl_q[0] <= rd_last_q;
      pp_q[0] <= rd_pass_q;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pv_q[k] <= pv_q[k-1];
        pl_q[k] <= pl_q[k-1];
        pp_q[k] <= pp_q[k-1];
      end
    end
  end

  // FIFO storage; contents need no reset because the count gates every read of it
  always_ff @(posedge i_clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= {i_rd_data, pl_q[READ_LATENCY-1], pp_q[READ_LATENCY-1]};
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Show-ahead head entry, forced to zero while the FIFO is empty
  assign head     = fifo_mem[rd_ptr];
  assign o_tvalid = (fifo_count != '0);
  assign o_tdata  = o_tvalid ? head[EW-1 -: WW] : '0;
  assign o_tlast  = o_tvalid & head[REPEAT_WIDTH];
  assign o_tuser  = o_tvalid ? head[REPEAT_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_mem_streams_rd_ctrl.sv
// tb/tb_mem_streams_rd_ctrl.sv - self-checking bench for mem_streams_rd_ctrl
module tb_mem_streams_rd_ctrl;

  localparam int CH = 16;
  localparam int DW = 64;
  localparam int AW = 11;
  localparam int L  = 3;
  localparam int RW = 4;
  localparam int FD = 8;
  localparam int WW = CH * DW;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [AW-1:0] i_frame_len;
  logic [RW-1:0] i_repeat;
  logic          o_rd_ren;
  logic [AW-1:0] o_rd_addr;
  logic [WW-1:0] i_rd_data;
  logic [WW-1:0] o_tdata;
  logic          o_tvalid;
  logic          i_tready;
  logic          o_tlast;
  logic [RW-1:0] o_tuser;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  mem_streams_rd_ctrl #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .READ_LATENCY(L), .REPEAT_WIDTH(RW), .FIFO_DEPTH(FD)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
    .i_frame_len(i_frame_len), .i_repeat(i_repeat),
    .o_rd_ren(o_rd_ren), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .i_tready(i_tready),
    .o_tlast(o_tlast), .o_tuser(o_tuser), .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct {
    logic [WW-1:0] d;
    logic          l;
    logic [RW-1:0] u;
  } beat_t;

  // tmode: 0 ready always, 1 stall 15 cycles after first valid then toggle, 2 random
  typedef struct {
    int len;
    int rep;
    int tmode;
    int start2_off;
    int exp_reads;
    int exp_first_valid;
    int exp_done;
  } vec_t;

  int    cyc, checks, errors, cur_mode;
  int    sched [int];
  int    rd_addr_q [$];
  int    rd_cyc_q [$];
  beat_t got_q [$];
  vec_t  tbl [$];
  int    first_valid_cyc, done_cyc, done_cnt, pops, peak, busy_cnt, busy_at_done, stab_err;
  logic  prev_hold;
  beat_t prev_b;

  function automatic logic [WW-1:0] pat(input int a);
    logic [WW-1:0] v;
    for (int i = 0; i < CH; i++) begin
      v[i*DW +: DW] = ((64'(a) + 64'd1) * 64'h9E37_79B9_7F4A_7C15) ^ (64'(i) << 56);
    end
    return v;
  endfunction

  function automatic logic [WW-1:0] rnd();
    logic [WW-1:0] v;
    for (int i = 0; i < WW / 32; i++) begin
      v[i*32 +: 32] = $urandom;
    end
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_sb();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    got_q.delete();
    first_valid_cyc = -1;
    done_cyc        = -1;
    done_cnt        = 0;
    pops            = 0;
    peak            = 0;
    busy_cnt        = 0;
    busy_at_done    = -1;
    stab_err        = 0;
    prev_hold       = 1'b0;
  endtask

  // One cycle: observe outputs at the falling edge, play the RAM, then drive inputs
  task automatic tick(input logic start, input int len, input int rep, input logic rst);
    beat_t b;
    @(negedge clk);
    cyc++;
    if (o_done) begin
      done_cnt++;
      if (done_cyc < 0) begin
        done_cyc     = cyc;
        busy_at_done = int'(o_busy);
      end
    end
    if (o_busy) busy_cnt++;
    if (o_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (o_rd_ren) begin
      rd_addr_q.push_back(int'(o_rd_addr));
      rd_cyc_q.push_back(cyc);
      sched[cyc + L] = int'(o_rd_addr);
    end
    if (rd_addr_q.size() - pops > peak) peak = rd_addr_q.size() - pops;
    b.d = o_tdata;
    b.l = o_tlast;
    b.u = o_tuser;
    if (prev_hold && (!o_tvalid || b.d != prev_b.d || b.l != prev_b.l || b.u != prev_b.u))
      stab_err++;
    if (sched.exists(cyc)) begin
      i_rd_data = pat(sched[cyc]);
      sched.delete(cyc);
    end else begin
      i_rd_data = rnd();
    end
    case (cur_mode)
      0: i_tready = 1'b1;
      1: begin
        if (first_valid_cyc < 0) i_tready = 1'b1;
        else if (cyc < first_valid_cyc + 15) i_tready = 1'b0;
        else i_tready = (cyc % 2) != 0;
      end
      default: i_tready = ($urandom_range(0, 3) != 0);
    endcase
    if (o_tvalid && i_tready && !rst) begin
      got_q.push_back(b);
      pops++;
    end
    prev_hold   = o_tvalid && !i_tready && !rst;
    prev_b      = b;
    i_start     = start;
    i_frame_len = AW'(len);
    i_repeat    = RW'(rep);
    i_reset     = rst;
  endtask

  // Runs one request and compares against the frame/pass model
  task automatic run_req(input vec_t v, input string tag);
    int    t0, n, mism, nreads, a;
    beat_t e;
    clear_sb();
    cur_mode = v.tmode;
    tick(1'b1, v.len, v.rep, 1'b0);
    t0 = cyc;
    n  = 0;
    while (done_cyc < 0 && n < 2000) begin
      if (n == v.start2_off) tick(1'b1, 7, 3, 1'b0);
      else tick(1'b0, 0, 0, 1'b0);
      n++;
    end
    chk({tag, " done_seen"}, int'(done_cyc >= 0), 1);
    for (int i = 0; i < 4; i++) tick(1'b0, 0, 0, 1'b0);

    nreads = v.len * (v.rep + 1);
    chk({tag, " reads"}, rd_addr_q.size(), v.exp_reads);
    chk({tag, " beats"}, got_q.size(), nreads);
    chk({tag, " done_pulses"}, done_cnt, 1);

    mism = 0;
    for (int i = 0; i < nreads && i < rd_addr_q.size(); i++)
      if (rd_addr_q[i] != i % v.len) mism++;
    chk({tag, " addr_seq"}, mism, 0);

    if (v.tmode == 0) begin
      mism = 0;
      for (int i = 0; i < rd_cyc_q.size(); i++)
        if (rd_cyc_q[i] != t0 + 1 + i) mism++;
      chk({tag, " read_contiguous"}, mism, 0);
    end

    mism = 0;
    for (int i = 0; i < got_q.size() && i < nreads; i++) begin
      a   = i % v.len;
      e.d = pat(a);
      e.l = (a == v.len - 1);
      e.u = RW'(i / v.len);
      if (got_q[i].d != e.d || got_q[i].l != e.l || got_q[i].u != e.u) begin
        if (mism == 0)
          $display("  %s beat %0d differs: last=%0d user=%0d lane0=%h, wanted last=%0d user=%0d lane0=%h",
                   tag, i, got_q[i].l, got_q[i].u, got_q[i].d[DW-1:0], e.l, e.u, e.d[DW-1:0]);
        mism++;
      end
    end
    chk({tag, " beat_content"}, mism, 0);

    if (v.exp_first_valid >= 0) chk({tag, " first_valid_lat"}, first_valid_cyc - t0, v.exp_first_valid);
    if (v.exp_done >= 0) chk({tag, " done_lat"}, done_cyc - t0, v.exp_done);
    chk({tag, " busy_at_done"}, busy_at_done, 0);
    chk({tag, " busy_cycles"}, busy_cnt, (v.len == 0) ? 0 : done_cyc - t0 - 1);
    chk({tag, " stable_while_stalled"}, stab_err, 0);
    chk({tag, " no_overfill"}, int'(peak > FD), 0);
    if (v.tmode == 1) chk({tag, " credit_peak"}, peak, FD);
  endtask

  initial begin
    vec_t v;
    int   nr, base_reads;
    i_reset     = 1'b1;
    i_start     = 1'b0;
    i_frame_len = '0;
    i_repeat    = '0;
    i_tready    = 1'b1;
    i_rd_data   = '0;
    cyc         = 0;
    checks      = 0;
    errors      = 0;
    cur_mode    = 0;
    clear_sb();

    repeat (3) tick(1'b0, 0, 0, 1'b1);
    tick(1'b0, 0, 0, 1'b0);
    chk("reset o_rd_ren", int'(o_rd_ren), 0);
    chk("reset o_rd_addr", int'(o_rd_addr), 0);
    chk("reset o_tvalid", int'(o_tvalid), 0);
    chk("reset o_tlast", int'(o_tlast), 0);
    chk("reset o_tuser", int'(o_tuser), 0);
    chk("reset o_tdata_nonzero", int'(o_tdata != '0), 0);
    chk("reset o_busy", int'(o_busy), 0);
    chk("reset o_done", int'(o_done), 0);

    // len, rep, tmode, start2_off, exp_reads, exp_first_valid, exp_done
    tbl.push_back('{4,  0, 0, -1,  4,  5,  9});
    tbl.push_back('{3,  2, 0, -1,  9,  5, 14});
    tbl.push_back('{20, 0, 1, -1, 20,  5, -1});
    tbl.push_back('{0,  0, 0, -1,  0, -1,  1});
    tbl.push_back('{5,  1, 0,  3, 10,  5, 15});
    tbl.push_back('{1,  0, 0, -1,  1,  5,  6});
    tbl.push_back('{1,  3, 0, -1,  4,  5,  9});
    for (int r = 0; r < 6; r++) begin
      v.len             = $urandom_range(1, 12);
      v.rep             = $urandom_range(0, 3);
      v.tmode           = (r % 2 == 0) ? 0 : 2;
      v.start2_off      = -1;
      nr                = v.len * (v.rep + 1);
      v.exp_reads       = nr;
      v.exp_first_valid = L + 2;
      v.exp_done        = (v.tmode == 0) ? nr + L + 2 : -1;
      tbl.push_back(v);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      run_req(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a stalled run with the FIFO partly full
    clear_sb();
    cur_mode = 1;
    tick(1'b1, 20, 0, 1'b0);
    repeat (12) tick(1'b0, 0, 0, 1'b0);
    chk("midrun fifo_holding_data", int'(o_tvalid), 1);
    tick(1'b0, 0, 0, 1'b1);
    tick(1'b0, 0, 0, 1'b0);
    chk("midrun_reset o_rd_ren", int'(o_rd_ren), 0);
    chk("midrun_reset o_rd_addr", int'(o_rd_addr), 0);
    chk("midrun_reset o_tvalid", int'(o_tvalid), 0);
    chk("midrun_reset o_tlast", int'(o_tlast), 0);
    chk("midrun_reset o_tuser", int'(o_tuser), 0);
    chk("midrun_reset o_tdata_nonzero", int'(o_tdata != '0), 0);
    chk("midrun_reset o_busy", int'(o_busy), 0);
    chk("midrun_reset o_done", int'(o_done), 0);
    base_reads = rd_addr_q.size();
    repeat (30) tick(1'b0, 0, 0, 1'b0);
    chk("midrun_reset no_done_after", done_cnt, 0);
    chk("midrun_reset no_reads_after", rd_addr_q.size(), base_reads);
    sched.delete();
    run_req(tbl[0], "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
